// File: rtl/nclic_pkg.sv
// Shared types and constants for the nclic core-side entry logic.
package nclic_pkg;

  typedef logic [4:0] IntIndex;
  typedef logic [3:0] IntPriority;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    VECTOR,
    RETURN
  } entry_state_e;

  localparam int unsigned VecEntryBytes = 4;

  // Handler address for a zero-extended index; 32-bit add wraps naturally.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] idx_zx);
    return base + (idx_zx * 32'(VecEntryBytes));
  endfunction

endpackage

// File: rtl/nclic_prio_stack.sv
// Synchronous LIFO of preempted {index, priority} pairs.
// Push when full and pop/replace when empty are silently ignored; the
// caller decides whether that is an error.
module nclic_prio_stack #(
  parameter int W     = 9,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          replace_top,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] depth
);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] top_ptr;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign depth   = cnt;
  assign wr_ptr  = AW'(cnt);
  assign top_ptr = AW'(cnt - CW'(1));
  assign top     = empty ? '0 : mem[top_ptr];

  // Storage and occupancy; push wins over pop, pop over replace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_ptr] <= din;
      cnt         <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end else if (replace_top && !empty) begin
      mem[top_ptr] <= din;
    end
  end

endmodule

// File: rtl/nclic_entry.sv
// Core-side responder to the interrupt controller dispatch interface.
// Accepts dispatches, stacks preempted (index, priority) pairs, strobes the
// pending-clear ack and hands the handler vector to fetch over valid/ready.
// Optional: define NCLIC_ENTRY_STACK_GUARD_EN to flag stack overflow and
// underflow on a sticky o_err and redirect overflowing entries to VecBase.
module nclic_entry #(
  parameter type         IntIndex    = nclic_pkg::IntIndex,
  parameter type         IntPriority = nclic_pkg::IntPriority,
  parameter int          IntAmount   = 32,
  parameter int          StackDepth  = 8,
  parameter logic [31:0] VecBase     = 32'h0000_0000,
  localparam int         DepthW      = $clog2(StackDepth + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_int,
  input  IntIndex           i_idx,
  input  IntPriority        i_prio,
  input  logic              i_ret,
  output logic              o_mret,
  output logic              o_vec_valid,
  input  logic              i_vec_ready,
  output logic [31:0]       o_vec_addr,
  output logic              o_ack,
  output IntIndex           o_ack_idx,
  output IntIndex           o_run_idx,
  output IntPriority        o_run_prio,
  output logic [DepthW-1:0] o_depth,
  output logic              o_stall,
  output logic              o_err
);

  import nclic_pkg::*;

  localparam int IW   = $bits(IntIndex);
  localparam int PW   = $bits(IntPriority);
  localparam int StkW = IW + PW;
  // The vector table only spans IntAmount entries; higher index bits are
  // never legitimately set, so they do not reach the address adder.
  localparam int TblW = (IntAmount > 1) ? $clog2(IntAmount) : 1;
  localparam int IdxW = (TblW < IW) ? TblW : IW;

  entry_state_e state, state_n;

  IntIndex    lat_idx, run_idx, top_idx;
  IntPriority lat_prio, run_prio, top_prio;
  logic       tail_q;

  logic            push_req, stk_push, stk_pop;
  logic            stk_full, stk_empty;
  logic [StkW-1:0] stk_top;
  logic            ack, vec_valid, mret;
  logic [31:0]     vec_target;

  assign push_req = (state == IDLE) && i_int && !i_ret;
  assign stk_push = push_req && !stk_full;

  nclic_prio_stack #(
    .W     (StkW),
    .DEPTH (StackDepth)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push        (stk_push),
    .pop         (stk_pop),
    .replace_top (1'b0),
    .din         ({run_idx, run_prio}),
    .top         (stk_top),
    .full        (stk_full),
    .empty       (stk_empty),
    .depth       (o_depth)
  );

  assign top_idx  = IntIndex'(stk_top[StkW-1 -: IW]);
  assign top_prio = IntPriority'(stk_top[PW-1:0]);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and per-state strobes; requests are only looked at in IDLE.
  always_comb begin
    state_n   = state;
    stk_pop   = 1'b0;
    ack       = 1'b0;
    vec_valid = 1'b0;
    mret      = 1'b0;
    o_stall   = 1'b1;
    case (state)
      IDLE: begin
        o_stall = 1'b0;
        if (i_int)      state_n = ENTRY;
        else if (i_ret) state_n = RETURN;
      end
      ENTRY: begin
        ack     = 1'b1;
        mret    = tail_q;
        state_n = VECTOR;
      end
      VECTOR: begin
        vec_valid = 1'b1;
        if (i_vec_ready) state_n = IDLE;
      end
      RETURN: begin
        stk_pop = 1'b1;
        mret    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Latch the dispatch in IDLE, commit it as running in ENTRY, and restore
  // the preempted context in RETURN (an empty stack leaves it untouched).
  // A tail chain is remembered so ENTRY can also strobe mret; the old
  // handler's slot is simply overwritten, the stack is not touched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_idx  <= '0;
      lat_prio <= '0;
      run_idx  <= '0;
      run_prio <= '0;
      tail_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_int) begin
          lat_idx  <= i_idx;
          lat_prio <= i_prio;
          tail_q   <= i_ret;
        end
        ENTRY: begin
          run_idx  <= lat_idx;
          run_prio <= lat_prio;
        end
        RETURN: if (!stk_empty) begin
          run_idx  <= top_idx;
          run_prio <= top_prio;
        end
        default: ;
      endcase
    end
  end

`ifdef NCLIC_ENTRY_STACK_GUARD_EN
  logic fault_q, err_q;

  // Overflowing entry goes to the fault vector; any stack misuse is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if ((state == IDLE) && i_int) fault_q <= push_req && stk_full;
      if ((push_req && stk_full) || ((state == RETURN) && stk_empty))
        err_q <= 1'b1;
    end
  end

  assign o_err      = err_q;
  assign vec_target = fault_q ? VecBase : vec_addr(VecBase, 32'(lat_idx[IdxW-1:0]));
`else
  assign o_err      = 1'b0;
  assign vec_target = vec_addr(VecBase, 32'(lat_idx[IdxW-1:0]));
`endif

  assign o_ack       = ack;
  assign o_ack_idx   = ack ? lat_idx : '0;
  assign o_vec_valid = vec_valid;
  assign o_vec_addr  = vec_valid ? vec_target : '0;
  assign o_mret      = mret;
  assign o_run_idx   = run_idx;
  assign o_run_prio  = run_prio;

endmodule
